// File: rtl/airlock_port_array.sv
// airlock_port_array: N-port airlock door controller with a one-door-at-a-time interlock.
// Define AIRLOCK_DEBOUNCE_EN to add a per-switch debounce filter ahead of edge detection.
module airlock_port_array #(
    parameter int NUM_PORTS     = 2,
    parameter int TRAVEL_CYCLES = 5,
`ifdef AIRLOCK_DEBOUNCE_EN
    parameter int DEBOUNCE_CYC  = 3,
`endif
    parameter int CNT_W         = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NUM_PORTS-1:0] SwitchFlip,
    input  logic [NUM_PORTS-1:0] PressOK,
    output logic [NUM_PORTS-1:0] DoorOpen,
    output logic [NUM_PORTS-1:0] DoorMoving,
    output logic                 Busy,
    output logic [NUM_PORTS-1:0] Denied
);

    typedef enum logic [1:0] {
        CLOSED,
        OPENING,
        OPEN,
        CLOSING
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);

    logic [NUM_PORTS-1:0] sw_q;
    logic [NUM_PORTS-1:0] sw_p;
    logic [NUM_PORTS-1:0] req;

`ifdef AIRLOCK_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [NUM_PORTS-1:0] sw_s;
    logic [CNT_W-1:0]     deb_q [NUM_PORTS];

    // sw_q only follows sw_s once it has disagreed for DEBOUNCE_CYC cycles in a row
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_s <= '0;
            sw_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            sw_s <= SwitchFlip;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (sw_s[i] == sw_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DEB_LAST) begin
                    sw_q[i]  <= sw_s[i];
                    deb_q[i] <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_q <= '0;
        end else begin
            sw_q <= SwitchFlip;
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_p <= '0;
        end else begin
            sw_p <= sw_q;
        end
    end

    assign req = sw_q & ~sw_p;

    state_t               state_q [NUM_PORTS];
    state_t               state_d [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] closed;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] deny_d;
    logic [NUM_PORTS-1:0] open_d;
    logic [NUM_PORTS-1:0] mov_d;

    // Grant needs every other door closed and no lower-index contender
    always_comb begin
        closed = '0;
        grant  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            closed[i] = (state_q[i] == CLOSED);
        end
        cand = req & PressOK;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (j != i && !closed[j]) begin
                    grant[i] = 1'b0;
                end
                if (j < i && cand[j]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        deny_d = '0;
        open_d = '0;
        mov_d  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                CLOSED: begin
                    if (req[i]) begin
                        if (grant[i]) begin
                            state_d[i] = OPENING;
                            cnt_d[i]   = '0;
                        end else begin
                            deny_d[i] = 1'b1;
                        end
                    end
                end
                OPENING: begin
                    if (cnt_q[i] == TRAVEL_LAST) begin
                        state_d[i] = OPEN;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                OPEN: begin
                    // Lost pressure forces a close without flagging Denied
                    if (req[i] || !PressOK[i]) begin
                        state_d[i] = CLOSING;
                        cnt_d[i]   = '0;
                    end
                end
                CLOSING: begin
                    if (cnt_q[i] == TRAVEL_LAST) begin
                        state_d[i] = CLOSED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = CLOSED;
                    cnt_d[i]   = '0;
                end
            endcase
            open_d[i] = (state_d[i] == OPEN);
            mov_d[i]  = (state_d[i] == OPENING) || (state_d[i] == CLOSING);
        end
    end

    // Outputs are registered from next state so they line up with state_q
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= CLOSED;
                cnt_q[i]   <= '0;
            end
            DoorOpen   <= '0;
            DoorMoving <= '0;
            Busy       <= 1'b0;
            Denied     <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            DoorOpen   <= open_d;
            DoorMoving <= mov_d;
            Busy       <= |(open_d | mov_d);
            Denied     <= deny_d;
        end
    end

endmodule

// File: tb/tb_airlock_port_array.sv
// tb_airlock_port_array: directed stimulus, cycle-level door model and literal spot checks.
// Runs the AIRLOCK_DEBOUNCE_EN scenario instead of the main one when that macro is defined.
module tb_airlock_port_array;

    localparam int NP  = 2;
    localparam int T   = 4;
    localparam int DEB = 3;

    logic          clk = 1'b0;
    logic          Reset;
    logic [NP-1:0] SwitchFlip;
    logic [NP-1:0] PressOK;
    logic [NP-1:0] DoorOpen;
    logic [NP-1:0] DoorMoving;
    logic          Busy;
    logic [NP-1:0] Denied;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  chk_en    = 1'b0;

    always #5 clk = ~clk;

    airlock_port_array #(
        .NUM_PORTS    (NP),
        .TRAVEL_CYCLES(T),
        .CNT_W        (8)
    ) dut (
        .Clock     (clk),
        .Reset     (Reset),
        .SwitchFlip(SwitchFlip),
        .PressOK   (PressOK),
        .DoorOpen  (DoorOpen),
        .DoorMoving(DoorMoving),
        .Busy      (Busy),
        .Denied    (Denied)
    );

    // Model: phase 0 closed, 1 opening, 2 open, 3 closing; left = edges still to travel
    int            ph    [NP];
    int            left  [NP];
    int            nph   [NP];
    int            nleft [NP];
    logic [NP-1:0] flt1, flt2;
    logic [NP-1:0] raw_h [$];
    logic [NP-1:0] m_req, m_nf, m_den;
    logic [NP-1:0] e_open, e_mov, e_den;
    logic          e_busy;
    bit            g, all_flip;

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NP; i++) begin
                ph[i]   = 0;
                left[i] = 0;
            end
            flt1  = '0;
            flt2  = '0;
            m_den = '0;
            raw_h.delete();
        end else begin
            m_req = flt1 & ~flt2;
`ifdef AIRLOCK_DEBOUNCE_EN
            m_nf = flt1;
            if (raw_h.size() >= DEB) begin
                for (int i = 0; i < NP; i++) begin
                    all_flip = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        if (raw_h[j][i] == flt1[i]) all_flip = 1'b0;
                    end
                    if (all_flip) m_nf[i] = ~flt1[i];
                end
            end
`else
            m_nf = SwitchFlip;
`endif
            raw_h.push_front(SwitchFlip);
            if (raw_h.size() > 16) void'(raw_h.pop_back());
            flt2  = flt1;
            flt1  = m_nf;
            m_den = '0;
            for (int i = 0; i < NP; i++) begin
                nph[i]   = ph[i];
                nleft[i] = left[i];
                case (ph[i])
                    0: if (m_req[i]) begin
                        g = PressOK[i];
                        for (int j = 0; j < NP; j++) begin
                            if (j != i && ph[j] != 0) g = 1'b0;
                            if (j < i && m_req[j] && PressOK[j]) g = 1'b0;
                        end
                        if (g) begin
                            nph[i]   = 1;
                            nleft[i] = T;
                        end else begin
                            m_den[i] = 1'b1;
                        end
                    end
                    1: begin
                        nleft[i] = left[i] - 1;
                        if (nleft[i] == 0) nph[i] = 2;
                    end
                    2: if (m_req[i] || !PressOK[i]) begin
                        nph[i]   = 3;
                        nleft[i] = T;
                    end
                    default: begin
                        nleft[i] = left[i] - 1;
                        if (nleft[i] == 0) nph[i] = 0;
                    end
                endcase
            end
            for (int i = 0; i < NP; i++) begin
                ph[i]   = nph[i];
                left[i] = nleft[i];
            end
        end
        for (int i = 0; i < NP; i++) begin
            e_open[i] = (ph[i] == 2);
            e_mov[i]  = (ph[i] == 1) || (ph[i] == 3);
        end
        e_den  = m_den;
        e_busy = |(e_open | e_mov);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total_cnt++;
            if ({DoorOpen, DoorMoving, Busy, Denied} === {e_open, e_mov, e_busy, e_den})
                pass_cnt++;
            else
                $display("FAIL model t=%0t got open=%b mov=%b busy=%b den=%b need open=%b mov=%b busy=%b den=%b",
                         $time, DoorOpen, DoorMoving, Busy, Denied, e_open, e_mov, e_busy, e_den);
            total_cnt++;
            if ($countones(DoorOpen | DoorMoving) <= 1)
                pass_cnt++;
            else
                $display("FAIL interlock t=%0t got open=%b mov=%b need at most one door active",
                         $time, DoorOpen, DoorMoving);
        end
    end

    function automatic logic [6:0] outs();
        return {DoorOpen, DoorMoving, Busy, Denied};
    endfunction

    task automatic lit(input string nm, input logic [6:0] exp);
        logic [6:0] got;
        got = outs();
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%b need=%b (open,mov,busy,den)", nm, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [NP-1:0] m);
        SwitchFlip = m;
        @(negedge clk);
        SwitchFlip = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset      = 1'b1;
        PressOK    = 2'b11;
        SwitchFlip = '0;
        repeat (2) tick();
        chk_en = 1'b1;
        lit("reset", 7'b00_00_0_00);
        Reset = 1'b0;
`ifdef AIRLOCK_DEBOUNCE_EN
        SwitchFlip = 2'b01;
        repeat (2) tick();
        SwitchFlip = '0;
        repeat (8) tick();
        lit("deb_glitch", 7'b00_00_0_00);
        SwitchFlip = 2'b01;
        repeat (4) tick();
        lit("deb_wait", 7'b00_00_0_00);
        tick();
        lit("deb_open", 7'b00_01_1_00);
        repeat (8) tick();
        lit("deb_opened", 7'b01_00_1_00);
`else
        // single door open and close
        pulse(2'b01);
        lit("t2_latency", 7'b00_00_0_00);
        tick();
        lit("t2_opening", 7'b00_01_1_00);
        repeat (3) tick();
        lit("t2_opening_last", 7'b00_01_1_00);
        tick();
        lit("t2_open", 7'b01_00_1_00);
        tick();
        lit("t2_fall_ignored", 7'b01_00_1_00);
        pulse(2'b01);
        tick();
        lit("t2_closing", 7'b00_01_1_00);
        repeat (3) tick();
        tick();
        lit("t2_closed", 7'b00_00_0_00);

        // blocked by an open door
        pulse(2'b01);
        repeat (5) tick();
        lit("t3_open", 7'b01_00_1_00);
        pulse(2'b10);
        tick();
        lit("t3_denied", 7'b01_00_1_10);
        tick();
        lit("t3_denied_end", 7'b01_00_1_00);
        pulse(2'b01);
        repeat (5) tick();
        lit("t3_closed", 7'b00_00_0_00);

        // tie, plus a request ignored mid-travel
        pulse(2'b11);
        tick();
        lit("t4_tie", 7'b00_01_1_10);
        pulse(2'b01);
        repeat (3) tick();
        lit("t4_open", 7'b01_00_1_00);

        // pressure loss while open
        PressOK = 2'b10;
        tick();
        lit("t5_forced", 7'b00_01_1_00);
        repeat (4) tick();
        lit("t5_closed", 7'b00_00_0_00);
        pulse(2'b01);
        tick();
        lit("t5_no_press", 7'b00_00_0_01);
        PressOK = 2'b11;
        tick();

        // pressure loss while opening
        pulse(2'b01);
        tick();
        PressOK = 2'b10;
        repeat (3) tick();
        tick();
        lit("t5b_open", 7'b01_00_1_00);
        tick();
        lit("t5b_close", 7'b00_01_1_00);
        PressOK = 2'b11;
        repeat (4) tick();
        lit("t5b_closed", 7'b00_00_0_00);

        // door 1 blocks door 0
        pulse(2'b10);
        repeat (5) tick();
        lit("p1_open", 7'b10_00_1_00);
        pulse(2'b01);
        tick();
        lit("p1_blocks_p0", 7'b10_00_1_01);
        pulse(2'b10);
        repeat (5) tick();
        lit("p1_closed", 7'b00_00_0_00);

        // reset mid-travel
        pulse(2'b10);
        tick();
        lit("t6_moving", 7'b00_10_1_00);
        tick();
        Reset = 1'b1;
        tick();
        lit("t6_reset", 7'b00_00_0_00);
        Reset = 1'b0;
        repeat (3) tick();
        lit("t6_idle", 7'b00_00_0_00);
`endif
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
